// File: rtl/code_deserializer_pkg.sv
// code_pkg: shared code-word width and deserializer state type.
package code_pkg;
  localparam int CODE_W = 4;
  typedef enum logic {COLLECT, FULL} deser_state_t;
  typedef logic [CODE_W-1:0] code_t;
endpackage

// File: rtl/code_deserializer.sv
// code_deserializer: serial-to-parallel code word assembler with valid/ready output and double buffering.
module code_deserializer
  import code_pkg::*;
#(
  parameter int W = CODE_W,
  parameter int MSB_FIRST = 1,
  parameter int SLIDING = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sync,
  input  logic         din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic [W-1:0] b_o,
  output logic         b_valid,
  input  logic         b_ready,
  output logic         overrun,
  input  logic         clr_overrun
);
  localparam int CW = $clog2(W + 1);
  deser_state_t state, state_n;
  logic [CW-1:0] cnt, c, cnt_n;
  logic [W-1:0] sh, sh_n;
  logic primed, pr, accept, last, complete, slot_free, load;
  always_comb begin
    din_ready = state == COLLECT;
    accept = din_valid && din_ready;
    c = sync ? '0 : cnt;
    pr = !sync && primed;
    last = c == CW'(W - 1);
    sh_n = accept ? ((MSB_FIRST != 0) ? {sh[W-2:0], din} : {din, sh[W-1:1]}) : sh;
    complete = accept && (last || (SLIDING != 0 && pr));
    slot_free = !b_valid || b_ready;
    load = slot_free && (complete || state == FULL);
    state_n = (complete && !slot_free) ? FULL : ((state == FULL && slot_free) ? COLLECT : state);
    cnt_n = accept ? (last ? '0 : c + 1'b1) : c;
  end
  // sh is only written on accepted bits, so a pending word in FULL survives sync
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= COLLECT;
      cnt <= '0;
      sh <= '0;
      primed <= 1'b0;
      b_o <= '0;
      b_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sh <= sh_n;
      primed <= pr || (accept && last);
      if (load) b_o <= complete ? sh_n : sh;
      b_valid <= load || (b_valid && !b_ready);
      overrun <= (din_valid && !din_ready) || (overrun && !clr_overrun);
    end
  end
endmodule
